tcn_fifo_decoder: RTL and testbench



---
 rtl/tcn_fifo_decoder_pkg.sv | 27 ++
 rtl/tcn_fifo_decoder_pointer.sv | 39 +++
 rtl/tcn_fifo_decoder.sv | 112 +++++++++++
 tb/tb_tcn_fifo_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tcn_fifo_decoder_pkg.sv
// Shared definitions for the TCN activation FIFO decoder and its checkers.
// fifo_decode is the inverse of the encoder's logical->physical rotation.
package tcn_fifo_decoder_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned BLK_W  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // All arithmetic wraps at ADDR_W bits, matching the encoder.
  function automatic logic [ADDR_W-1:0] fifo_decode(input logic [ADDR_W-1:0] phys,
                                                    input logic [ADDR_W-1:0] offset,
                                                    input logic [ADDR_W-1:0] total);
    logic [ADDR_W-1:0] sum;
    sum = phys + offset;
    if (sum < total) begin
      return sum;
    end else begin
      return sum - total;
    end
  endfunction

endpackage

// File: rtl/tcn_fifo_decoder_pointer.sv
// FIFO block pointer: registered update pulse plus wrap counter.
// Shared with the encoder so both sides advance in lockstep.
module tcn_fifo_pointer #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              update_pointer,
  input  logic [ADDR_W-1:0] total_blocks,
  output logic [ADDR_W-1:0] fifo_pointer
);

  logic              upd_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_q) begin
      if (ptr_q == total_blocks - ADDR_W'(1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      upd_q <= update_pointer;
      ptr_q <= ptr_d;
    end
  end

  assign fifo_pointer = ptr_q;

endmodule

// File: rtl/tcn_fifo_decoder.sv
// Walks one physical window of the circular activation buffer and emits the
// decoded logical address per beat, with a mirrored FIFO block pointer.
module tcn_fifo_decoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned BLK_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_active,
  input  logic [ADDR_W-1:0] cfg_total_blocks,
  input  logic [BLK_W-1:0]  cfg_block_size,
  input  logic              update_pointer,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_phys_addr,
  output logic [ADDR_W-1:0] out_logical_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fifo_pointer
);

  import tcn_fifo_decoder_pkg::*;

  state_e            state_q;
  logic [ADDR_W-1:0] total_q, offset_q, phys_q, logical_q;
  logic              valid_q, last_q, busy_q, done_q;

  logic [ADDR_W-1:0] blk_size, total, offset, offset_eff, phys_nxt;

  tcn_fifo_pointer #(
    .ADDR_W(ADDR_W)
  ) u_pointer (
    .clk           (clk),
    .reset         (reset),
    .update_pointer(update_pointer),
    .total_blocks  (cfg_total_blocks),
    .fifo_pointer  (fifo_pointer)
  );

  assign blk_size   = cfg_block_size[ADDR_W-1:0];
  assign total      = cfg_total_blocks * blk_size;
  assign offset     = fifo_pointer * blk_size;
  // Zero offset makes the decode an identity since phys < total throughout.
  assign offset_eff = cfg_active ? offset : '0;
  assign phys_nxt   = phys_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      total_q   <= '0;
      offset_q  <= '0;
      phys_q    <= '0;
      logical_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (total != '0) begin
              state_q   <= StRun;
              total_q   <= total;
              offset_q  <= offset_eff;
              phys_q    <= '0;
              logical_q <= fifo_decode('0, offset_eff, total);
              valid_q   <= 1'b1;
              last_q    <= (total == ADDR_W'(1));
              busy_q    <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRun: begin
          // Without out_ready every output register simply holds.
          if (out_ready) begin
            if (last_q) begin
              state_q <= StDone;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              phys_q    <= phys_nxt;
              logical_q <= fifo_decode(phys_nxt, offset_q, total_q);
              last_q    <= (phys_nxt == total_q - ADDR_W'(1));
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign out_valid        = valid_q;
  assign out_phys_addr    = phys_q;
  assign out_logical_addr = logical_q;
  assign out_last         = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_tcn_fifo_decoder.sv
// Directed bench for tcn_fifo_decoder: window walks, pointer mirror, stalls,
// zero-size windows and mid-walk reset against hand-computed expectations.
module tb_tcn_fifo_decoder;

  logic        clk;
  logic        reset;
  logic        cfg_active;
  logic [7:0]  cfg_total_blocks;
  logic [15:0] cfg_block_size;
  logic        update_pointer;
  logic        start;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_phys_addr;
  logic [7:0]  out_logical_addr;
  logic        out_last;
  logic        busy;
  logic        done;
  logic [7:0]  fifo_pointer;

  int n_checks = 0;
  int n_pass   = 0;

  tcn_fifo_decoder dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_active      (cfg_active),
    .cfg_total_blocks(cfg_total_blocks),
    .cfg_block_size  (cfg_block_size),
    .update_pointer  (update_pointer),
    .start           (start),
    .out_ready       (out_ready),
    .out_valid       (out_valid),
    .out_phys_addr   (out_phys_addr),
    .out_logical_addr(out_logical_addr),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done),
    .fifo_pointer    (fifo_pointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_update();
    update_pointer = 1'b1;
    tick();
    update_pointer = 1'b0;
  endtask

  // One full window walk; expected logical address is (phys + off) mod tot.
  task automatic run_walk(input int tot, input int off, input bit stall, input int upd_beat);
    int  beat;
    int  cyc;
    bit  acc;
    bit  pulsed;
    beat   = 0;
    cyc    = 0;
    pulsed = 1'b0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    while (beat < tot && cyc < tot * 4 + 20) begin
      check_eq("valid", out_valid, 1);
      check_eq("phys", out_phys_addr, beat);
      check_eq("logical", out_logical_addr, (beat + off) % tot);
      check_eq("last", out_last, (beat == tot - 1));
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = out_ready;
      if (beat == upd_beat && !pulsed) begin
        update_pointer = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      update_pointer = 1'b0;
      if (acc) beat++;
      cyc++;
    end
    check_eq("beats_done", beat, tot);
    check_eq("done_pulse", done, 1);
    check_eq("valid_after", out_valid, 0);
    out_ready = 1'b1;
    tick();
    check_eq("done_clear", done, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    out_ready = 1'b1;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    check_eq("drain_done", done, 1);
    tick();
  endtask

  initial begin
    reset            = 1'b0;
    cfg_active       = 1'b1;
    cfg_total_blocks = 8'd4;
    cfg_block_size   = 16'd16;
    update_pointer   = 1'b0;
    start            = 1'b0;
    out_ready        = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_phys", out_phys_addr, 0);
    check_eq("rst_logical", out_logical_addr, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ptr", fifo_pointer, 0);
    reset = 1'b1;
    tick();

    // Pointer 0: identity mapping over 64 beats.
    run_walk(64, 0, 1'b0, -1);

    // One pulse: pointer still 0 one cycle later, 1 two cycles later.
    pulse_update();
    check_eq("ptr_t1", fifo_pointer, 0);
    tick();
    check_eq("ptr_t2", fifo_pointer, 1);
    run_walk(64, 16, 1'b0, -1);

    // Inactive mode ignores the pointer.
    cfg_active = 1'b0;
    run_walk(64, 0, 1'b0, -1);
    cfg_active = 1'b1;

    // Random stalls.
    run_walk(64, 16, 1'b1, -1);

    // Pulse mid-walk: this walk keeps offset 16, the next uses 32.
    run_walk(64, 16, 1'b0, 10);
    check_eq("ptr_mid", fifo_pointer, 2);
    run_walk(64, 32, 1'b0, -1);

    // Reset at beat 20 aborts the walk and clears the pointer.
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check_eq("pre_rst_phys", out_phys_addr, 20);
    reset = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_phys", out_phys_addr, 0);
    check_eq("arst_logical", out_logical_addr, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_ptr", fifo_pointer, 0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("post_rst_valid", out_valid, 0);

    // Four pulses wrap the pointer: 1, 2, 3, 0.
    for (int i = 1; i <= 4; i++) begin
      pulse_update();
      check_eq("wrap_old", fifo_pointer, i - 1);
      tick();
      check_eq("wrap_new", fifo_pointer, i % 4);
    end

    // Start one cycle after a pulse latches the old offset.
    pulse_update();
    tick();
    check_eq("ptr_is1", fifo_pointer, 1);
    pulse_update();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("old_off_logical", out_logical_addr, 16);
    check_eq("old_off_ptr", fifo_pointer, 2);
    drain();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("new_off_logical", out_logical_addr, 32);
    drain();

    // Zero-size window: no beats, done the next cycle.
    cfg_total_blocks = 8'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("zero_valid", out_valid, 0);
    check_eq("zero_done", done, 1);
    check_eq("zero_busy", busy, 0);
    tick();
    check_eq("zero_done_clr", done, 0);
    check_eq("zero_valid2", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
